seg_counter_display: RTL and testbench
======================================

Name: seg_counter_display

Overview:
- Parametrised up/down counter with a selectable binary or Johnson count sequence.
- Drives DIGITS active-low seven-segment hex digits from the count value.
- Successor to the fixed 5-bit, two-digit display decoder, which had no counting of its own.
- Adds an internal registered counter, direction control, parallel load, terminal-count flag and registered display outputs; sits between board switches/buttons and the HEX displays.

Parameters:
- WIDTH, 8: counter width in bits, 2..32.
- DIGITS, 2: number of seven-segment digits driven. Must be >= ceil(WIDTH/4); digits above the count width always display 0.

Ports:
- clk  in  1: system clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- en  in  1: count enable.
- mode  in  1: 0 = binary, 1 = Johnson (twisted ring).
- up  in  1: 1 = count up / shift left, 0 = count down / shift right.
- load  in  1: parallel load strobe.
- load_val  in  WIDTH: value loaded when load=1.
- count  out  WIDTH: current counter state.
- tc  out  1: terminal-count pulse.
- segs  out  7*DIGITS: active-low segments, bit order gfedcba per digit; digit k occupies segs[7k+6:7k] and shows count nibble k.

Behaviour:
- Priority per edge: rst > load > en > hold.
- Reset values: count=0, tc=0, every digit = 1000000 ("0").
- rst held high keeps all outputs at reset values. Reset mid-count or coincident with load: reset wins; load_val is ignored.
- load=1: count<=load_val next edge, regardless of en/mode/up; tc<=0.
- Binary, en=1:
  - up=1: count<=count+1 mod 2^WIDTH.
  - up=0: count<=count-1 mod 2^WIDTH.
- Johnson, en=1:
  - up=1: count<={count[WIDTH-2:0], ~count[WIDTH-1]}.
  - up=0: count<={~count[0], count[WIDTH-1:1]}.
  - Period is 2*WIDTH states.
  - No correction of illegal Johnson patterns, from load or mode switch; the state shifts as-is.
- mode/up changes take effect on the next enabled edge. count is never altered by a mode change alone.
- tc is registered and is 1 only in the cycle after an edge on which the count wrapped:
  - binary up all-ones->0;
  - binary down 0->all-ones;
  - Johnson, either direction, any transition into 0.
  - Otherwise tc=0, including during hold and load.
- segs are registered from count: exactly 1 cycle of latency after count changes.
- Hex encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- A partial top nibble (WIDTH not a multiple of 4) is zero-extended.

Optional Feature:
- Macro: SEG_COUNTER_DISPLAY_LZB_EN (leading-zero blanking).
- Defined: every digit above the most significant non-zero nibble outputs 1111111 (blank). Digit 0 is never blanked, so count=0 shows a single "0". Latency and reset values are unchanged, except that reset shows digit 0 = 1000000 and all other digits = 1111111.
- Undefined: all DIGITS digits are always driven, with leading zeros shown.

Test Plan (WIDTH=8, DIGITS=2):
- rst=1 one cycle, then en=0 -> count=0x00, tc=0, segs={1000000,1000000}, held for 5 cycles.
- load 0xFE, then en=1 mode=0 up=1 for 2 edges:
  - count 0xFF then 0x00;
  - tc=1 only in the cycle after the 0xFF->0x00 edge;
  - segs={0001110,0001110} one cycle after count=0xFF.
- mode=0 up=0 from 0x00, en=1 -> count=0xFF, tc=1 for one cycle; next edge count=0xFE, tc=0.
- From reset, mode=1 up=1 en=1 for 16 edges:
  - count 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00;
  - tc=1 only after the 16th edge.
- load=1 load_val=0x5A with en=1 -> count=0x5A; next cycle segs={0010010,0001000}; tc=0.
- rst=1 and load=1 together mid-count -> count=0x00 next edge, tc=0. With SEG_COUNTER_DISPLAY_LZB_EN defined, count=0x05 -> segs={1111111,0010010}.

Source files
------------

// File: rtl/seg_counter_display.sv
// rtl/seg_counter_display.sv - binary/Johnson up/down counter driving registered active-low hex digits
// Optional leading-zero blanking: define SEG_COUNTER_DISPLAY_LZB_EN
module seg_counter_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   segs
);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [WIDTH-1:0]    step_val;
  logic                wrap;
  logic [4*DIGITS-1:0] padded;
  logic [7*DIGITS-1:0] segs_next;
  logic [7*DIGITS-1:0] segs_rst;

  always_comb begin
    step_val = count;
    wrap     = 1'b0;
    if (!mode) begin
      if (up) begin
        step_val = count + 1'b1;
        wrap     = &count;
      end else begin
        step_val = count - 1'b1;
        wrap     = ~|count;
      end
    end else begin
      if (up) step_val = {count[WIDTH-2:0], ~count[WIDTH-1]};
      else    step_val = {~count[0], count[WIDTH-1:1]};
      // A zero state can never shift into zero, so this flags only real arrivals.
      wrap = ~|step_val;
    end
  end

  always_comb begin
    logic seen;
    padded            = '0;
    padded[WIDTH-1:0] = count;
    segs_next         = '0;
    segs_rst          = '0;
    seen              = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen = seen | (|padded[4*k +: 4]);
`ifdef SEG_COUNTER_DISPLAY_LZB_EN
      segs_next[7*k +: 7] = (seen || k == 0) ? hex7(padded[4*k +: 4]) : SEG_BLANK;
      segs_rst[7*k +: 7]  = (k == 0) ? SEG_ZERO : SEG_BLANK;
`else
      segs_next[7*k +: 7] = hex7(padded[4*k +: 4]);
      segs_rst[7*k +: 7]  = SEG_ZERO;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      segs  <= segs_rst;
    end else begin
      segs <= segs_next;
      if (load) begin
        count <= load_val;
        tc    <= 1'b0;
      end else if (en) begin
        count <= step_val;
        tc    <= wrap;
      end else begin
        tc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_counter_display.sv
// tb/tb_seg_counter_display.sv - directed self-checking bench for seg_counter_display (WIDTH=8, DIGITS=2)
module tb_seg_counter_display;

  logic        clk = 1'b0;
  logic        rst, en, mode, up, load;
  logic [7:0]  load_val;
  logic [7:0]  count;
  logic        tc;
  logic [13:0] segs;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SB = 7'b1111111;

  seg_counter_display #(.WIDTH(8), .DIGITS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .up(up), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .segs(segs)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] jseq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                            8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  initial begin
    rst = 1; en = 0; mode = 0; up = 1; load = 0; load_val = 8'h00;
    step();
    check_val("rst_count", count, 8'h00);
    check_val("rst_tc", tc, 1'b0);
    check_val("rst_segs", segs, {S0, S0});
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("hold_count", count, 8'h00);
      check_val("hold_tc", tc, 1'b0);
      check_val("hold_segs", segs, {S0, S0});
    end

    load = 1; load_val = 8'hFE;
    step();
    check_val("load_fe", count, 8'hFE);
    check_val("load_tc", tc, 1'b0);
    load = 0; en = 1; mode = 0; up = 1;
    step();
    check_val("up_ff", count, 8'hFF);
    check_val("up_ff_tc", tc, 1'b0);
    check_val("segs_fe", segs, {SF, SE});
    step();
    check_val("up_wrap", count, 8'h00);
    check_val("up_wrap_tc", tc, 1'b1);
    check_val("segs_ff", segs, {SF, SF});

    up = 0;
    step();
    check_val("dn_wrap", count, 8'hFF);
    check_val("dn_wrap_tc", tc, 1'b1);
    step();
    check_val("dn_fe", count, 8'hFE);
    check_val("dn_fe_tc", tc, 1'b0);

    en = 0; mode = 1;
    step();
    check_val("mode_hold", count, 8'hFE);
    check_val("mode_hold_tc", tc, 1'b0);

    rst = 1;
    step();
    check_val("rst2_count", count, 8'h00);
    rst = 0; en = 1; mode = 1; up = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      check_val("john_up", count, jseq[i]);
      check_val("john_up_tc", tc, (i == 15) ? 1'b1 : 1'b0);
    end

    load = 1; load_val = 8'h01;
    step();
    load = 0; up = 0;
    step();
    check_val("john_dn", count, 8'h00);
    check_val("john_dn_tc", tc, 1'b1);
    step();
    check_val("john_dn2", count, 8'h80);
    check_val("john_dn2_tc", tc, 1'b0);

    load = 1; load_val = 8'h5A; en = 1;
    step();
    check_val("load_5a", count, 8'h5A);
    check_val("load_5a_tc", tc, 1'b0);
    load = 0; en = 0;
    step();
    check_val("segs_5a", segs, {S5, SA});
    check_val("segs_5a_tc", tc, 1'b0);

    en = 1; mode = 0; up = 1;
    step();
    step();
    rst = 1; load = 1; load_val = 8'h77;
    step();
    check_val("rst_load_count", count, 8'h00);
    check_val("rst_load_tc", tc, 1'b0);
    rst = 0; load = 1; load_val = 8'h05; en = 0;
    step();
    load = 0;
    step();
    check_val("count_05", count, 8'h05);
`ifdef SEG_COUNTER_DISPLAY_LZB_EN
    check_val("segs_05", segs, {SB, S5});
`else
    check_val("segs_05", segs, {S0, S5});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
